// File: rtl/uart_count_reporter_pkg.sv
// Shared constants and state encoding for the count reporter.
// ASCII bytes and FSM states used by the top and its tests.
package uart_count_reporter_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD,
    WAIT
  } state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_count_reporter_if.sv
// Byte handshake between the count reporter and uart_tx.
// master = reporter side, slave = transmitter side.
interface uart_count_reporter_if;

  logic       start_trigger;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output start_trigger,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  start_trigger,
    input  tx_data,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_count_reporter_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, DATA_W cycles.
// valid pulses for one cycle once bcd holds the final result.
module bin2bcd_seq #(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    valid
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     adj;
  logic [DATA_W-1:0] bin_q;
  logic [CW-1:0]     cnt_q;
  logic              valid_q;

  // add-3 correction on every digit that would overflow on shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        bcd_q <= '0;
        bin_q <= bin;
        cnt_q <= CW'(DATA_W);
      end else if (cnt_q != '0) begin
        bcd_q   <= {adj[BW-2:0], bin_q[DATA_W-1]};
        bin_q   <= {bin_q[DATA_W-2:0], 1'b0};
        cnt_q   <= cnt_q - 1'b1;
        valid_q <= (cnt_q == CW'(1));
      end
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;

endmodule

// File: rtl/uart_count_reporter.sv
// Latches a count, converts it to decimal and streams it as
// ASCII (optionally CR LF) into uart_tx one byte at a time.
module uart_count_reporter
  import uart_count_reporter_pkg::*;
#(
  parameter int DATA_W       = 14,
  parameter int NUM_DIGITS   = 4,
  parameter int SEND_CRLF    = 1,
  parameter int LEADING_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_W-1:0]     value,
  uart_count_reporter_if.master tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NB = NUM_DIGITS + 2 * SEND_CRLF;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] MAXV = 32'(pow10(NUM_DIGITS) - 1);

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic bcd_valid;
  logic done_q, done_d;
  logic accept;
  logic last;
  logic [DATA_W-1:0] value_c;
  logic [NUM_DIGITS-1:0][7:0] chars;
  logic [7:0] cur_byte;
  logic [3:0] dig;
  logic seen;

  // a req landing on the done cycle belongs to the finished frame
  assign accept  = (state_q == IDLE) && req && !done_q;
  assign value_c = (32'(value) > MAXV) ? DATA_W'(MAXV) : value;
  assign last    = (idx_q == IW'(NB - 1));

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (value_c),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  always_comb begin
    chars = '0;
    dig   = '0;
    seen  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      dig = digits_q[4*k +: 4];
      if (LEADING_ZERO == 0 && !seen && dig == 4'd0 && k != 0) begin
        chars[k] = ASCII_SPACE;
      end else begin
        chars[k] = ASCII_ZERO + {4'h0, dig};
      end
      seen = seen | (dig != 4'd0);
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(idx_q) == NUM_DIGITS - 1 - k) begin
        cur_byte = chars[k];
      end
    end
    if (SEND_CRLF != 0) begin
      if (int'(idx_q) == NUM_DIGITS) cur_byte = ASCII_CR;
      if (int'(idx_q) == NUM_DIGITS + 1) cur_byte = ASCII_LF;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    done_d           = 1'b0;
    tx.start_trigger = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CONVERT;
      end
      CONVERT: begin
        if (bcd_valid) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (!tx.tx_busy) begin
          tx.start_trigger = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (tx.tx_done) begin
          if (last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (state_q == CONVERT && bcd_valid) begin
        digits_q <= bcd;
      end
    end
  end

  assign tx.tx_data = (state_q == LOAD || state_q == WAIT) ? cur_byte : 8'h00;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_uart_count_reporter.sv
// Bench for uart_count_reporter: two instances (leading zeros on/off)
// driven by a uart_tx model, checked against an arithmetic reference.
module tb_uart_count_reporter;

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic [13:0] value;
  logic busy0, done0, busy1, done1;
  logic hold;
  logic mb0 = 1'b0;
  logic mb1 = 1'b0;
  int cnt0 = 0;
  int cnt1 = 0;
  int viol0 = 0;
  int viol1 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  int tcap0[$];

  uart_count_reporter_if i0 ();
  uart_count_reporter_if i1 ();

  assign i0.tx_busy = mb0 | hold;
  assign i1.tx_busy = mb1 | hold;

  uart_count_reporter #(.LEADING_ZERO(1)) dut0 (
    .clk(clk), .rst(rst), .req(req), .value(value),
    .tx(i0.master), .busy(busy0), .done(done0)
  );

  uart_count_reporter #(.LEADING_ZERO(0)) dut1 (
    .clk(clk), .rst(rst), .req(req), .value(value),
    .tx(i1.master), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  // uart_tx model: busy for 10 cycles after a start, then tx_done
  always @(posedge clk) begin
    i0.tx_done <= 1'b0;
    if (i0.start_trigger) begin
      if (i0.tx_busy) viol0 <= viol0 + 1;
      cap0.push_back(i0.tx_data);
      tcap0.push_back(cyc);
      mb0  <= 1'b1;
      cnt0 <= 10;
    end else if (mb0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) begin
        mb0        <= 1'b0;
        i0.tx_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    i1.tx_done <= 1'b0;
    if (i1.start_trigger) begin
      if (i1.tx_busy) viol1 <= viol1 + 1;
      cap1.push_back(i1.tx_data);
      mb1  <= 1'b1;
      cnt1 <= 10;
    end else if (mb1) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) begin
        mb1        <= 1'b0;
        i1.tx_done <= 1'b1;
      end
    end
  end

  // expected byte p (0 = first sent) of the reply for value v
  function automatic logic [7:0] exp_byte(input int v, input bit lz,
                                          input int p);
    int c, d, pw;
    c = (v > 9999) ? 9999 : v;
    if (p == 4) return 8'h0D;
    if (p == 5) return 8'h0A;
    pw = 1;
    for (int k = 0; k < 3 - p; k++) pw = pw * 10;
    d = (c / pw) % 10;
    if (!lz && p < 3 && c < pw) return 8'h20;
    return 8'(8'h30 + d);
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nvec++;
    if (i0.start_trigger !== 1'b0) begin
      nerr++;
      $display("FAIL reset_start: got %b want 0", i0.start_trigger);
    end
    nvec++;
    if (i0.tx_data !== 8'h00) begin
      nerr++;
      $display("FAIL reset_data: got %h want 00", i0.tx_data);
    end
    nvec++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy: got %b%b want 00", busy0, busy1);
    end
    nvec++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_done: got %b%b want 00", done0, done1);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if (busy0 !== 1'b0 || cap0.size() != 0) begin
      nerr++;
      $display("FAIL reset_release: busy %b bytes %0d want 0 0",
               busy0, cap0.size());
    end
  endtask

  // one request; optional tx_busy hold and optional ignored 2nd req
  task automatic test_frame(input int v, input int hold_cyc, input int v2);
    int b0, b1, dc0, dc1, t, k;
    logic [7:0] got, want;
    b0  = cap0.size();
    b1  = cap1.size();
    dc0 = done_cnt0;
    dc1 = done_cnt1;
    @(negedge clk);
    hold  = (hold_cyc > 0);
    req   = 1'b1;
    value = 14'(v);
    t     = cyc;
    @(negedge clk);
    req   = 1'b0;
    value = 14'($urandom);
    if (hold_cyc > 0) begin
      repeat (hold_cyc) @(negedge clk);
      nvec++;
      if (cap0.size() != b0 || cap1.size() != b1) begin
        nerr++;
        $display("FAIL hold_no_start: got %0d bytes want 0",
                 cap0.size() - b0);
      end
      nvec++;
      if (busy0 !== 1'b1) begin
        nerr++;
        $display("FAIL hold_busy: got %b want 1", busy0);
      end
      hold = 1'b0;
    end
    if (v2 >= 0) begin
      repeat (30) @(negedge clk);
      req   = 1'b1;
      value = 14'(v2);
      @(negedge clk);
      req = 1'b0;
    end
    k = 0;
    while ((done_cnt0 == dc0 || done_cnt1 == dc1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (k >= 400) begin
      nerr++;
      $display("FAIL frame_timeout v=%0d: got no done want done", v);
    end
    repeat (4) @(negedge clk);
    nvec++;
    if (cap0.size() - b0 != 6 || cap1.size() - b1 != 6) begin
      nerr++;
      $display("FAIL frame_len v=%0d: got %0d/%0d want 6",
               v, cap0.size() - b0, cap1.size() - b1);
    end
    for (int p = 0; p < 6; p++) begin
      nvec++;
      got  = (b0 + p < cap0.size()) ? cap0[b0 + p] : 8'hxx;
      want = exp_byte(v, 1'b1, p);
      if (got !== want) begin
        nerr++;
        $display("FAIL byte_lz1 v=%0d p=%0d: got %h want %h",
                 v, p, got, want);
      end
      nvec++;
      got  = (b1 + p < cap1.size()) ? cap1[b1 + p] : 8'hxx;
      want = exp_byte(v, 1'b0, p);
      if (got !== want) begin
        nerr++;
        $display("FAIL byte_lz0 v=%0d p=%0d: got %h want %h",
                 v, p, got, want);
      end
    end
    nvec++;
    if (done_cnt0 - dc0 != 1 || done_cnt1 - dc1 != 1) begin
      nerr++;
      $display("FAIL done_once v=%0d: got %0d/%0d want 1",
               v, done_cnt0 - dc0, done_cnt1 - dc1);
    end
    nvec++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      nerr++;
      $display("FAIL busy_after v=%0d: got %b%b want 00", v, busy0, busy1);
    end
    nvec++;
    if (viol0 != 0 || viol1 != 0) begin
      nerr++;
      $display("FAIL start_while_busy: got %0d/%0d want 0", viol0, viol1);
    end
    if (hold_cyc == 0 && cap0.size() > b0) begin
      nvec++;
      if (tcap0[b0] - t != 16) begin
        nerr++;
        $display("FAIL latency v=%0d: got %0d want 16", v, tcap0[b0] - t);
      end
    end
  endtask

  task automatic test_basic();
    test_frame(1234, 0, -1);
    test_frame(9876, 0, -1);
  endtask

  task automatic test_blanking();
    test_frame(7, 0, -1);
    test_frame(0, 0, -1);
    test_frame(105, 0, -1);
    test_frame(1000, 0, -1);
  endtask

  task automatic test_clamp();
    test_frame(12000, 0, -1);
    test_frame(16383, 0, -1);
    test_frame(10000, 0, -1);
    test_frame(9999, 0, -1);
  endtask

  task automatic test_tx_busy_hold();
    test_frame(1234, 66, -1);
  endtask

  task automatic test_req_while_busy();
    test_frame(1234, 0, 5555);
    test_frame(5555, 0, -1);
  endtask

  task automatic test_req_at_done();
    int b0, k;
    b0 = cap0.size();
    @(negedge clk);
    req   = 1'b1;
    value = 14'd2468;
    @(negedge clk);
    req = 1'b0;
    k = 0;
    while (done0 !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (k >= 400) begin
      nerr++;
      $display("FAIL done_wait: got no done want done");
    end
    req   = 1'b1;
    value = 14'd4321;
    @(negedge clk);
    req = 1'b0;
    repeat (40) @(negedge clk);
    nvec++;
    if (cap0.size() - b0 != 6) begin
      nerr++;
      $display("FAIL req_at_done_len: got %0d want 6", cap0.size() - b0);
    end
    nvec++;
    if (busy0 !== 1'b0) begin
      nerr++;
      $display("FAIL req_at_done_busy: got %b want 0", busy0);
    end
  endtask

  task automatic test_reset_mid();
    int b0, b1, k;
    b0 = cap0.size();
    b1 = cap1.size();
    @(negedge clk);
    req   = 1'b1;
    value = 14'd1234;
    @(negedge clk);
    req = 1'b0;
    k = 0;
    while (cap0.size() - b0 < 3 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (busy0 !== 1'b1 || i0.tx_data !== 8'h33) begin
      nerr++;
      $display("FAIL mid_frame: got busy %b data %h want 1 33",
               busy0, i0.tx_data);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (i0.tx_data !== 8'h00 || i1.tx_data !== 8'h00) begin
      nerr++;
      $display("FAIL async_data: got %h/%h want 00", i0.tx_data, i1.tx_data);
    end
    nvec++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || i0.start_trigger !== 1'b0) begin
      nerr++;
      $display("FAIL async_busy: got %b%b%b want 000",
               busy0, busy1, i0.start_trigger);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    nvec++;
    if (cap0.size() - b0 != 3 || cap1.size() - b1 != 3) begin
      nerr++;
      $display("FAIL stray_start: got %0d/%0d want 3",
               cap0.size() - b0, cap1.size() - b1);
    end
    test_frame(9876, 0, -1);
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       v = int'($urandom_range(0, 16383));
        1:       v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(9990, 10010));
      endcase
      test_frame(v, 0, -1);
    end
  endtask

  initial begin
    rst   = 1'b0;
    req   = 1'b0;
    value = '0;
    hold  = 1'b0;
    test_reset();
    test_basic();
    test_blanking();
    test_clamp();
    test_tx_busy_hold();
    test_req_while_busy();
    test_req_at_done();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
